// File: rtl/dmem_access_ctrl.sv
// D-cache access sequencer for the instruction leaving ID/EX: issues lookups, stalls EX/MEM
// on a miss, waits for the refill (or a timeout) and replays the lookup.
module dmem_access_ctrl #(
  parameter int unsigned HART_ID_W = 2,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned TMR_W     = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 access_mem,
  input  logic [HART_ID_W-1:0] id_hart_id,
  input  logic                 flush,
  input  logic                 dc_hit,
  input  logic                 dc_fill_done,
  output logic                 dc_req,
  output logic [HART_ID_W-1:0] dc_hart_id,
  output logic                 ex_stall,
  output logic                 miss_busy,
  output logic [HART_ID_W-1:0] miss_hart_id,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     miss_cnt
);

  typedef enum logic [1:0] {StIdle, StLookup, StMiss, StRetry} state_e;

  localparam logic [TMR_W-1:0] TimerLast = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};

  state_e                 state_q, state_d;
  logic [HART_ID_W-1:0]   req_hart_q, req_hart_d;
  logic [HART_ID_W-1:0]   miss_hart_id_q, miss_hart_id_d;
  logic                   miss_busy_q, miss_busy_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic                   abort_q, abort_d;
  logic [CNT_W-1:0]       miss_cnt_q, miss_cnt_d;
  logic                   timeout_err_q, timeout_err_d;

  always_comb begin
    state_d        = state_q;
    req_hart_d     = req_hart_q;
    miss_hart_id_d = miss_hart_id_q;
    miss_busy_d    = miss_busy_q;
    timer_d        = timer_q;
    abort_d        = abort_q;
    miss_cnt_d     = miss_cnt_q;
    timeout_err_d  = 1'b0;
    dc_req         = 1'b0;
    dc_hart_id     = '0;
    ex_stall       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (access_mem && !flush) begin
          dc_req     = 1'b1;
          dc_hart_id = id_hart_id;
          req_hart_d = id_hart_id;
          state_d    = StLookup;
        end
      end
      StLookup: begin
        if (flush) begin
          state_d = StIdle;
        end else if (dc_hit) begin
          if (access_mem) begin
            dc_req     = 1'b1;
            dc_hart_id = id_hart_id;
            req_hart_d = id_hart_id;
          end else begin
            state_d = StIdle;
          end
        end else begin
          ex_stall       = 1'b1;
          miss_busy_d    = 1'b1;
          miss_hart_id_d = req_hart_q;
          timer_d        = '0;
          state_d        = StMiss;
          if (miss_cnt_q != CntMax) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
          end
        end
      end
      StMiss: begin
        ex_stall = 1'b1;
        timer_d  = timer_q + TMR_W'(1);
        if (flush) begin
          abort_d = 1'b1;
        end
        // A fill wins over a coincident timeout; a flush in the fill cycle still aborts.
        if (dc_fill_done) begin
          abort_d = 1'b0;
          if (abort_q || flush) begin
            miss_busy_d = 1'b0;
            state_d     = StIdle;
          end else begin
            state_d = StRetry;
          end
        end else if (timer_q == TimerLast) begin
          timeout_err_d = 1'b1;
          miss_busy_d   = 1'b0;
          abort_d       = 1'b0;
          state_d       = StIdle;
        end
      end
      StRetry: begin
        ex_stall    = 1'b1;
        dc_req      = 1'b1;
        dc_hart_id  = req_hart_q;
        miss_busy_d = 1'b0;
        state_d     = StLookup;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      req_hart_q     <= '0;
      miss_hart_id_q <= '0;
      miss_busy_q    <= 1'b0;
      timer_q        <= '0;
      abort_q        <= 1'b0;
      miss_cnt_q     <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_hart_q     <= req_hart_d;
      miss_hart_id_q <= miss_hart_id_d;
      miss_busy_q    <= miss_busy_d;
      timer_q        <= timer_d;
      abort_q        <= abort_d;
      miss_cnt_q     <= miss_cnt_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign miss_busy    = miss_busy_q;
  assign miss_hart_id = miss_hart_id_q;
  assign timeout_err  = timeout_err_q;
  assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: hit, miss/refill, back-to-back hits, flush, timeout,
// counter saturation and asynchronous reset.
module tb_dmem_access_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       access_mem;
  logic [1:0] id_hart_id;
  logic       flush;
  logic       dc_hit;
  logic       dc_fill_done;
  logic       dc_req;
  logic [1:0] dc_hart_id;
  logic       ex_stall;
  logic       miss_busy;
  logic [1:0] miss_hart_id;
  logic       timeout_err;
  logic [1:0] miss_cnt;

  int tests = 0;
  int fails = 0;

  dmem_access_ctrl #(
    .HART_ID_W(2),
    .TIMEOUT  (8),
    .TMR_W    (8),
    .CNT_W    (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .access_mem  (access_mem),
    .id_hart_id  (id_hart_id),
    .flush       (flush),
    .dc_hit      (dc_hit),
    .dc_fill_done(dc_fill_done),
    .dc_req      (dc_req),
    .dc_hart_id  (dc_hart_id),
    .ex_stall    (ex_stall),
    .miss_busy   (miss_busy),
    .miss_hart_id(miss_hart_id),
    .timeout_err (timeout_err),
    .miss_cnt    (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic drv(input logic am, input logic [1:0] hid, input logic fl, input logic hit,
                     input logic fd);
    @(negedge clk);
    access_mem   = am;
    id_hart_id   = hid;
    flush        = fl;
    dc_hit       = hit;
    dc_fill_done = fd;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".dc_req"}, 32'(dc_req), 0);
    chk({tag, ".dc_hart_id"}, 32'(dc_hart_id), 0);
    chk({tag, ".ex_stall"}, 32'(ex_stall), 0);
    chk({tag, ".miss_busy"}, 32'(miss_busy), 0);
    chk({tag, ".miss_hart_id"}, 32'(miss_hart_id), 0);
    chk({tag, ".timeout_err"}, 32'(timeout_err), 0);
    chk({tag, ".miss_cnt"}, 32'(miss_cnt), 0);
  endtask

  initial begin
    reset = 1'b1;
    access_mem = 1'b0; id_hart_id = 2'd0; flush = 1'b0; dc_hit = 1'b0; dc_fill_done = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_all_zero("reset");
    reset = 1'b0;

    // Single hit.
    drv(1, 2, 0, 0, 0);
    chk("hit.req", 32'(dc_req), 1);
    chk("hit.hart", 32'(dc_hart_id), 2);
    chk("hit.stall0", 32'(ex_stall), 0);
    drv(0, 0, 0, 1, 0);
    chk("hit.req_drop", 32'(dc_req), 0);
    chk("hit.stall1", 32'(ex_stall), 0);
    drv(0, 0, 0, 0, 0);
    chk("hit.cnt", 32'(miss_cnt), 0);

    // Back-to-back hits.
    drv(1, 1, 0, 0, 0);
    chk("b2b.req0", 32'(dc_req), 1);
    chk("b2b.hart0", 32'(dc_hart_id), 1);
    drv(1, 3, 0, 1, 0);
    chk("b2b.req1", 32'(dc_req), 1);
    chk("b2b.hart1", 32'(dc_hart_id), 3);
    chk("b2b.stall1", 32'(ex_stall), 0);
    drv(1, 0, 0, 1, 0);
    chk("b2b.req2", 32'(dc_req), 1);
    chk("b2b.hart2", 32'(dc_hart_id), 0);
    chk("b2b.stall2", 32'(ex_stall), 0);
    drv(0, 0, 0, 1, 0);
    chk("b2b.req3", 32'(dc_req), 0);
    chk("b2b.stall3", 32'(ex_stall), 0);

    // Flush in the lookup cycle discards the hit result.
    drv(1, 1, 0, 0, 0);
    drv(1, 2, 1, 1, 0);
    chk("lkflush.req", 32'(dc_req), 0);
    chk("lkflush.stall", 32'(ex_stall), 0);
    drv(0, 0, 0, 0, 0);
    chk("lkflush.idle_stall", 32'(ex_stall), 0);
    chk("lkflush.cnt", 32'(miss_cnt), 0);

    // Miss with fill 5 cycles after the lookup: 7 stalled cycles and a replay.
    drv(1, 1, 0, 0, 0);
    chk("miss.req", 32'(dc_req), 1);
    drv(0, 0, 0, 0, 0);
    chk("miss.lk_stall", 32'(ex_stall), 1);
    chk("miss.lk_req", 32'(dc_req), 0);
    chk("miss.lk_busy", 32'(miss_busy), 0);
    for (int i = 0; i < 5; i++) begin
      drv(1, 2, 0, 0, (i == 4) ? 1'b1 : 1'b0);
      chk($sformatf("miss.m%0d_stall", i), 32'(ex_stall), 1);
      chk($sformatf("miss.m%0d_req", i), 32'(dc_req), 0);
      chk($sformatf("miss.m%0d_busy", i), 32'(miss_busy), 1);
    end
    chk("miss.hart", 32'(miss_hart_id), 1);
    chk("miss.cnt", 32'(miss_cnt), 1);
    drv(0, 0, 0, 0, 0);
    chk("retry.req", 32'(dc_req), 1);
    chk("retry.hart", 32'(dc_hart_id), 1);
    chk("retry.stall", 32'(ex_stall), 1);
    drv(0, 0, 0, 1, 0);
    chk("replay.stall", 32'(ex_stall), 0);
    chk("replay.busy", 32'(miss_busy), 0);
    chk("replay.req", 32'(dc_req), 0);

    // Flush at miss cycle 2, fill at cycle 4: no replay.
    drv(0, 0, 0, 1, 0);
    drv(1, 2, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    chk("fl.lk_stall", 32'(ex_stall), 1);
    for (int i = 0; i < 5; i++) begin
      drv(0, 0, (i == 2) ? 1'b1 : 1'b0, 0, (i == 4) ? 1'b1 : 1'b0);
      chk($sformatf("fl.m%0d_stall", i), 32'(ex_stall), 1);
    end
    chk("fl.cnt", 32'(miss_cnt), 2);
    drv(0, 0, 0, 0, 0);
    chk("fl.idle_req", 32'(dc_req), 0);
    chk("fl.idle_stall", 32'(ex_stall), 0);
    chk("fl.idle_busy", 32'(miss_busy), 0);
    drv(0, 0, 0, 0, 0);
    chk("fl.idle_req2", 32'(dc_req), 0);

    // Timeout: no fill, pulse 8 cycles after miss entry.
    drv(1, 3, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drv(0, 0, 0, 0, 0);
      chk($sformatf("to.m%0d_err", i), 32'(timeout_err), 0);
      chk($sformatf("to.m%0d_stall", i), 32'(ex_stall), 1);
    end
    chk("to.hart", 32'(miss_hart_id), 3);
    chk("to.cnt", 32'(miss_cnt), 3);
    drv(0, 0, 0, 0, 0);
    chk("to.err", 32'(timeout_err), 1);
    chk("to.stall", 32'(ex_stall), 0);
    chk("to.busy", 32'(miss_busy), 0);
    drv(0, 0, 0, 0, 0);
    chk("to.err_drop", 32'(timeout_err), 0);

    // Fourth miss: the 2-bit counter must hold at 3.
    drv(1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1);
    chk("sat.cnt", 32'(miss_cnt), 3);
    drv(0, 0, 0, 0, 0);
    chk("sat.retry_req", 32'(dc_req), 1);
    chk("sat.retry_hart", 32'(dc_hart_id), 0);
    drv(0, 0, 0, 1, 0);

    // Asynchronous reset in the middle of a miss.
    drv(1, 2, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    chk("ar.pre_stall", 32'(ex_stall), 1);
    #2 reset = 1'b1;
    #1 chk_all_zero("ar");
    @(negedge clk);
    reset = 1'b0;
    drv(0, 0, 0, 0, 1);
    chk("ar.fill_req", 32'(dc_req), 0);
    chk("ar.fill_stall", 32'(ex_stall), 0);
    drv(0, 0, 0, 0, 0);
    chk("ar.after_req", 32'(dc_req), 0);
    chk("ar.after_cnt", 32'(miss_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
